// File: rtl/serv_bus_arbiter_pkg.sv
// serv_bus_arbiter_pkg
//   Shared types and constants for the SERV bus arbiter slice:
//   FSM state encoding, last-grant flag encoding, default timeout and
//   the wait-counter width helper.
package serv_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        LAST_IBUS = 1'b0,
        LAST_DBUS = 1'b1
    } last_gnt_t;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    // Counter width for a given timeout; a disabled timeout (0) still
    // gets a 1-bit counter so no zero-width vector is ever declared.
    function automatic int unsigned wait_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/serv_bus_arbiter_if.sv
// serv_bus_arbiter_if
//   Bundles the instruction bus, data bus and shared Wishbone port of the
//   arbiter. Signal names keep the arbiter-relative i_/o_ prefixes.
//   Modports:
//     slave  - the arbiter: takes i_* requests/responses, drives o_*
//     master - the environment: drives i_*, observes o_*
interface serv_bus_arbiter_if;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;

    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;

    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;

    logic        o_timeout;

    modport slave (
        input  i_ibus_adr, i_ibus_cyc,
        input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        input  i_wb_rdt, i_wb_ack,
        output o_ibus_rdt, o_ibus_ack,
        output o_dbus_rdt, o_dbus_ack,
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        output o_timeout
    );

    modport master (
        output i_ibus_adr, i_ibus_cyc,
        output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        output i_wb_rdt, i_wb_ack,
        input  o_ibus_rdt, o_ibus_ack,
        input  o_dbus_rdt, o_dbus_ack,
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        input  o_timeout
    );
endinterface

// File: rtl/serv_bus_arbiter_wait_timer.sv
// serv_wait_timer
//   Counts grant cycles spent waiting for an acknowledge.
//   Ports:
//     clk     - clock
//     rst     - synchronous active-high reset
//     clear   - zero the count (held while the arbiter is idle)
//     enable  - count one waiting cycle
//     expired - count has reached TIMEOUT-1 (never set when TIMEOUT=0)
module serv_wait_timer
    import serv_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = wait_width(TIMEOUT);
    localparam logic [W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter
//   Shares one Wishbone master port between the SERV instruction and data
//   buses. Three-state FSM (IDLE, GNT_I, GNT_D), round-robin on ties via a
//   1-bit last-grant flag, and an optional wait timeout that completes a
//   stalled access with an error ack (rdt=0) and a one-cycle o_timeout.
//   Ports:
//     i_clk - clock, rising edge
//     i_rst - synchronous active-high reset
//     bus   - ibus/dbus request side and shared Wishbone port (slave modport)
module serv_bus_arbiter
    import serv_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                i_clk,
    input  logic                i_rst,
    serv_bus_arbiter_if.slave   bus
);

    arb_state_t state;
    last_gnt_t  last;

    logic gnt_i;
    logic gnt_d;
    logic active;
    logic ack;
    logic timeout;
    logic expired;
    logic leave;

    always_comb begin
        gnt_i   = (state == GNT_I);
        gnt_d   = (state == GNT_D);
        active  = (gnt_i && bus.i_ibus_cyc) || (gnt_d && bus.i_dbus_cyc);
        // Completions are suppressed while reset is asserted so a grant
        // interrupted by reset never acks either bus.
        ack     = active && bus.i_wb_ack && !i_rst;
        // A real ack in the limit cycle wins over the timeout.
        timeout = active && !bus.i_wb_ack && expired && !i_rst;
        leave   = (gnt_i && !bus.i_ibus_cyc) || (gnt_d && !bus.i_dbus_cyc) ||
                  ack || timeout;
    end

    always_comb begin
        bus.o_wb_adr = '0;
        bus.o_wb_dat = '0;
        bus.o_wb_sel = '0;
        bus.o_wb_we  = 1'b0;
        case (state)
            GNT_I: begin
                bus.o_wb_adr = bus.i_ibus_adr;
                bus.o_wb_sel = 4'hf;
            end
            GNT_D: begin
                bus.o_wb_adr = bus.i_dbus_adr;
                bus.o_wb_dat = bus.i_dbus_dat;
                bus.o_wb_sel = bus.i_dbus_sel;
                bus.o_wb_we  = bus.i_dbus_we;
            end
            default: ;
        endcase
        bus.o_wb_cyc   = active && !timeout;
        bus.o_ibus_ack = gnt_i && (ack || timeout);
        bus.o_ibus_rdt = (gnt_i && ack) ? bus.i_wb_rdt : '0;
        bus.o_dbus_ack = gnt_d && (ack || timeout);
        bus.o_dbus_rdt = (gnt_d && ack) ? bus.i_wb_rdt : '0;
        bus.o_timeout  = timeout;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            last  <= LAST_IBUS;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_ibus_cyc && bus.i_dbus_cyc) begin
                        state <= (last == LAST_IBUS) ? GNT_D : GNT_I;
                    end else if (bus.i_ibus_cyc) begin
                        state <= GNT_I;
                    end else if (bus.i_dbus_cyc) begin
                        state <= GNT_D;
                    end
                end
                GNT_I: begin
                    if (leave) begin
                        state <= IDLE;
                        last  <= LAST_IBUS;
                    end
                end
                GNT_D: begin
                    if (leave) begin
                        state <= IDLE;
                        last  <= LAST_DBUS;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Held clear throughout IDLE, so every grant starts counting from zero.
    serv_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) wait_timer (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (state == IDLE),
        .enable  (active && !bus.i_wb_ack),
        .expired (expired)
    );

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// tb_serv_bus_arbiter
//   Self-checking bench for serv_bus_arbiter (TIMEOUT=4). A table of full
//   transactions is applied in a loop; expected completions are queued when
//   a request is driven and popped when the DUT acks. Hand-written sequences
//   cover ack in IDLE, requester drop mid-grant and reset mid-grant.
module tb_serv_bus_arbiter;

    logic clk;
    logic rst;
    int unsigned total;
    int unsigned bad;

    serv_bus_arbiter_if bus ();

    serv_bus_arbiter #(
        .TIMEOUT(4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        icyc;
        logic        dcyc;
        logic [31:0] iadr;
        logic [31:0] dadr;
        logic [31:0] ddat;
        logic [3:0]  dsel;
        logic        dwe;
        int unsigned ack_cyc;   // grant cycle carrying i_wb_ack, 0 = never
        logic [31:0] rdt;
        logic        exp_d;     // 1 = dbus expected to be granted
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        logic [3:0]  exp_sel;
        logic        exp_we;
        int unsigned exp_cyc;   // grant cycle of the completion
        logic [31:0] exp_rdt;
        logic        exp_to;
    } vec_t;

    typedef struct {
        string       name;
        logic        is_d;
        logic [31:0] rdt;
        logic        to;
        int unsigned cyc;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    function automatic vec_t mk(
        input string name, input logic icyc, input logic dcyc,
        input logic [31:0] iadr, input logic [31:0] dadr, input logic [31:0] ddat,
        input logic [3:0] dsel, input logic dwe, input int unsigned ack_cyc,
        input logic [31:0] rdt, input logic exp_d, input logic [31:0] exp_adr,
        input logic [31:0] exp_dat, input logic [3:0] exp_sel, input logic exp_we,
        input int unsigned exp_cyc, input logic [31:0] exp_rdt, input logic exp_to);
        vec_t v;
        v.name = name;       v.icyc = icyc;       v.dcyc = dcyc;
        v.iadr = iadr;       v.dadr = dadr;       v.ddat = ddat;
        v.dsel = dsel;       v.dwe = dwe;         v.ack_cyc = ack_cyc;
        v.rdt = rdt;         v.exp_d = exp_d;     v.exp_adr = exp_adr;
        v.exp_dat = exp_dat; v.exp_sel = exp_sel; v.exp_we = exp_we;
        v.exp_cyc = exp_cyc; v.exp_rdt = exp_rdt; v.exp_to = exp_to;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input int unsigned k);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: got ack in grant cycle %0d expected no ack", k);
        end else begin
            total--;
            e = sb.pop_front();
            chk1({e.name, "/ack_bus"}, bus.o_dbus_ack, e.is_d);
            chk1({e.name, "/both_ack"}, bus.o_ibus_ack && bus.o_dbus_ack, 1'b0);
            chk32({e.name, "/rdt"}, e.is_d ? bus.o_dbus_rdt : bus.o_ibus_rdt, e.rdt);
            chk32({e.name, "/ack_cycle"}, k, e.cyc);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        bit   done;
        bus.i_ibus_cyc = v.icyc;
        bus.i_dbus_cyc = v.dcyc;
        bus.i_ibus_adr = v.iadr;
        bus.i_dbus_adr = v.dadr;
        bus.i_dbus_dat = v.ddat;
        bus.i_dbus_sel = v.dsel;
        bus.i_dbus_we  = v.dwe;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_rdt   = 32'h5a5a5a5a;
        e.name = v.name; e.is_d = v.exp_d; e.rdt = v.exp_rdt;
        e.to = v.exp_to; e.cyc = v.exp_cyc;
        sb.push_back(e);
        @(negedge clk);
        chk1({v.name, "/latency"}, bus.o_wb_cyc, 1'b0);
        step();
        done = 1'b0;
        for (int unsigned k = 1; k <= 6 && !done; k++) begin
            bus.i_wb_ack = (k == v.ack_cyc);
            bus.i_wb_rdt = (k == v.ack_cyc) ? v.rdt : 32'h5a5a5a5a;
            @(negedge clk);
            chk32({v.name, "/wb_adr"}, bus.o_wb_adr, v.exp_adr);
            chk32({v.name, "/wb_dat"}, bus.o_wb_dat, v.exp_dat);
            chk32({v.name, "/wb_sel"}, {28'b0, bus.o_wb_sel}, {28'b0, v.exp_sel});
            chk1({v.name, "/wb_we"}, bus.o_wb_we, v.exp_we);
            chk1({v.name, "/wb_cyc"}, bus.o_wb_cyc, !(v.exp_to && k == v.exp_cyc));
            chk1({v.name, "/timeout"}, bus.o_timeout, v.exp_to && k == v.exp_cyc);
            if (bus.o_ibus_ack || bus.o_dbus_ack) begin
                sb_check(k);
                done = 1'b1;
            end else begin
                chk32({v.name, "/rdt_quiet"}, bus.o_ibus_rdt | bus.o_dbus_rdt, 32'h0);
            end
            step();
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s/no_ack: got no ack in 6 grant cycles expected ack in cycle %0d",
                     v.name, v.exp_cyc);
            sb.delete();
        end
        bus.i_ibus_cyc = 1'b0;
        bus.i_dbus_cyc = 1'b0;
        bus.i_wb_ack   = 1'b0;
        @(negedge clk);
        chk32({v.name, "/idle_adr"}, bus.o_wb_adr, 32'h0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before 100us");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        //           name          ic dc iadr          dadr          ddat          dsel     we ack rdt           d  exp_adr       exp_dat       esel     ewe cyc exp_rdt       to
        vecs[0] = mk("tie_first",  1, 1, 32'h00001000, 32'h00002000, 32'h11112222, 4'b1100, 1, 1, 32'h00000077, 1, 32'h00002000, 32'h11112222, 4'b1100, 1, 1, 32'h00000077, 0);
        vecs[1] = mk("tie_second", 1, 1, 32'h00001000, 32'h00002000, 32'h11112222, 4'b1100, 1, 1, 32'h00000088, 0, 32'h00001000, 32'h00000000, 4'hf,    0, 1, 32'h00000088, 0);
        vecs[2] = mk("tie_third",  1, 1, 32'h00001000, 32'h00002000, 32'h11112222, 4'b1100, 1, 2, 32'h00000099, 1, 32'h00002000, 32'h11112222, 4'b1100, 1, 2, 32'h00000099, 0);
        vecs[3] = mk("fetch_100",  1, 0, 32'h00000100, 32'h00002000, 32'h33334444, 4'b0001, 1, 3, 32'h12345678, 0, 32'h00000100, 32'h00000000, 4'hf,    0, 3, 32'h12345678, 0);
        vecs[4] = mk("store_2000", 0, 1, 32'h00000500, 32'h00002000, 32'hdeadbeef, 4'b0011, 1, 1, 32'h00000000, 1, 32'h00002000, 32'hdeadbeef, 4'b0011, 1, 1, 32'h00000000, 0);
        vecs[5] = mk("load_dbus",  0, 1, 32'h00000500, 32'h00000044, 32'hffffffff, 4'hf,    0, 2, 32'hcafef00d, 1, 32'h00000044, 32'hffffffff, 4'hf,    0, 2, 32'hcafef00d, 0);
        vecs[6] = mk("ibus_tmo",   1, 0, 32'h00000200, 32'h00000044, 32'h00000000, 4'h0,    0, 0, 32'h00000000, 0, 32'h00000200, 32'h00000000, 4'hf,    0, 4, 32'h00000000, 1);
        vecs[7] = mk("dbus_ack4",  0, 1, 32'h00000200, 32'h00000300, 32'h00000005, 4'b0001, 0, 4, 32'h0badf00d, 1, 32'h00000300, 32'h00000005, 4'b0001, 0, 4, 32'h0badf00d, 0);
        vecs[8] = mk("dbus_tmo",   0, 1, 32'h00000200, 32'h00000304, 32'ha5a5a5a5, 4'hf,    1, 0, 32'h00000000, 1, 32'h00000304, 32'ha5a5a5a5, 4'hf,    1, 4, 32'h00000000, 1);
        vecs[9] = mk("ibus_ack4",  1, 0, 32'h00000204, 32'h00000304, 32'ha5a5a5a5, 4'hf,    1, 4, 32'h13572468, 0, 32'h00000204, 32'h00000000, 4'hf,    0, 4, 32'h13572468, 0);

        rst = 1'b1;
        bus.i_ibus_adr = '0; bus.i_ibus_cyc = 1'b0;
        bus.i_dbus_adr = '0; bus.i_dbus_dat = '0; bus.i_dbus_sel = '0;
        bus.i_dbus_we  = 1'b0; bus.i_dbus_cyc = 1'b0;
        bus.i_wb_rdt   = '0; bus.i_wb_ack = 1'b0;
        step();
        step();
        @(negedge clk);
        chk1("reset/wb_cyc", bus.o_wb_cyc, 1'b0);
        chk1("reset/timeout", bus.o_timeout, 1'b0);
        chk1("reset/acks", bus.o_ibus_ack | bus.o_dbus_ack, 1'b0);
        chk32("reset/wb_adr", bus.o_wb_adr, 32'h0);
        step();
        rst = 1'b0;

        // Ack while idle must not produce any completion.
        bus.i_ibus_adr = 32'h777; bus.i_dbus_adr = 32'h888;
        bus.i_wb_ack = 1'b1; bus.i_wb_rdt = 32'hffffffff;
        @(negedge clk);
        chk1("idle_ack/acks", bus.o_ibus_ack | bus.o_dbus_ack, 1'b0);
        chk32("idle_ack/rdt", bus.o_ibus_rdt | bus.o_dbus_rdt, 32'h0);
        chk1("idle_ack/wb_cyc", bus.o_wb_cyc, 1'b0);
        chk32("idle_ack/wb_adr", bus.o_wb_adr, 32'h0);
        step();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Data requester withdraws mid-grant: no ack, cyc drops at once.
        bus.i_dbus_cyc = 1'b1; bus.i_dbus_adr = 32'h3000; bus.i_dbus_we = 1'b0;
        bus.i_ibus_cyc = 1'b0; bus.i_ibus_adr = 32'h400; bus.i_wb_ack = 1'b0;
        step();
        @(negedge clk);
        chk1("drop/granted", bus.o_wb_cyc, 1'b1);
        chk32("drop/adr", bus.o_wb_adr, 32'h3000);
        step();
        bus.i_dbus_cyc = 1'b0;
        @(negedge clk);
        chk1("drop/wb_cyc", bus.o_wb_cyc, 1'b0);
        chk1("drop/acks", bus.o_ibus_ack | bus.o_dbus_ack, 1'b0);
        step();
        @(negedge clk);
        chk32("drop/idle_adr", bus.o_wb_adr, 32'h0);
        step();
        // Last grant was dbus even without an ack, so a tie now goes to ibus.
        bus.i_ibus_cyc = 1'b1; bus.i_dbus_cyc = 1'b1;
        @(negedge clk);
        chk1("rr_drop/idle", bus.o_wb_cyc, 1'b0);
        step();
        @(negedge clk);
        chk32("rr_drop/adr", bus.o_wb_adr, 32'h400);
        chk32("rr_drop/sel", {28'b0, bus.o_wb_sel}, 32'hf);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_mid/acks", bus.o_ibus_ack | bus.o_dbus_ack, 1'b0);
        chk1("rst_mid/timeout", bus.o_timeout, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_mid/wb_cyc", bus.o_wb_cyc, 1'b0);
        chk32("rst_mid/adr", bus.o_wb_adr, 32'h0);
        chk1("rst_mid/acks_after", bus.o_ibus_ack | bus.o_dbus_ack, 1'b0);
        step();
        // Reset restores last-grant=ibus, so the pending tie goes to dbus.
        @(negedge clk);
        chk32("rr_rst/adr", bus.o_wb_adr, 32'h3000);
        step();
        bus.i_ibus_cyc = 1'b0; bus.i_dbus_cyc = 1'b0;
        @(negedge clk);
        chk1("end/wb_cyc", bus.o_wb_cyc, 1'b0);
        chk32("end/sb_left", sb.size(), 32'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serv_bus_arbiter.md
SERV_BUS_ARBITER -- requirements
Module: serv_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning: cycles a grant may wait for i_wb_ack before an error completion; 0 disables the timeout.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 i_clk  input  1  clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  synchronous reset, active-high.
REQ-005 i_ibus_adr  input  32  instruction fetch address.
REQ-006 i_ibus_cyc  input  1  instruction fetch request.
REQ-007 o_ibus_rdt  output  32  fetch read data.
REQ-008 o_ibus_ack  output  1  fetch completion.
REQ-009 i_dbus_adr  input  32  data bus address.
REQ-010 i_dbus_dat  input  32  store data.
REQ-011 i_dbus_sel  input  4  byte lane select.
REQ-012 i_dbus_we  input  1  write enable.
REQ-013 i_dbus_cyc  input  1  data bus request.
REQ-014 o_dbus_rdt  output  32  load read data.
REQ-015 o_dbus_ack  output  1  data bus completion.
REQ-016 o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc  outputs  32/32/4/1/1  shared Wishbone master port.
REQ-017 i_wb_rdt, i_wb_ack  inputs  32/1  shared port read data and acknowledge.
REQ-018 o_timeout  output  1  one-cycle pulse on timeout completion.

Function
REQ-019 SHALL use a three-state FSM: IDLE, GNT_I, GNT_D.
REQ-020 In IDLE, a request on only one bus SHALL move the FSM to that bus's grant state on the next edge; grant latency is 1 cycle.
REQ-021 In IDLE, simultaneous requests SHALL grant the bus not granted last (round-robin on a 1-bit last-grant flag).
REQ-022 o_wb_cyc SHALL be (GNT_I & i_ibus_cyc) | (GNT_D & i_dbus_cyc), combinational from state.
REQ-023 Address, data, select and write-enable SHALL mux from the granted bus.
REQ-024 In GNT_I, o_wb_we, o_wb_sel and o_wb_dat SHALL be 0, 4'hf and 0 respectively.
REQ-025 In IDLE, all o_wb_* SHALL be 0.
REQ-026 i_wb_ack during a grant SHALL drive the granted bus's ack and rdt in the same cycle, combinationally.
REQ-027 i_wb_ack during a grant SHALL return the FSM to IDLE on the next edge and update the last-grant flag.
REQ-028 The non-granted bus SHALL see ack=0 and rdt=0.
REQ-029 i_wb_ack while in IDLE SHALL be ignored.
REQ-030 If the granted requester drops cyc before ack, the FSM SHALL return to IDLE on the next edge with no ack generated; the last-grant flag still updates.
REQ-031 A wait counter SHALL clear on entry to each grant state and increment per grant cycle without ack.
REQ-032 When the wait counter equals TIMEOUT-1 with no ack (TIMEOUT>0), the block SHALL assert the granted bus's ack with rdt=0 and pulse o_timeout for one cycle.
REQ-033 On that timeout, o_wb_cyc SHALL be forced to 0 in the same cycle and the FSM SHALL return to IDLE.
REQ-034 If i_wb_ack coincides with the timeout cycle, the real ack SHALL win: i_wb_rdt is forwarded and o_timeout stays 0.
REQ-035 The wait counter width SHALL be $clog2(TIMEOUT+1) and it SHALL never wrap.

Reset
REQ-036 Reset SHALL set state=IDLE, last-grant=ibus (so dbus wins the first tie), wait counter=0 and o_timeout=0.
REQ-037 Reset asserted mid-grant SHALL drop o_wb_cyc on the following cycle with no ack to either bus.

Structure
REQ-038 State encodings and the default TIMEOUT SHALL live in the shared serv package.
REQ-039 The wait counter SHALL be the sub-module serv_wait_timer (clear, enable, expired); all else stays flat.

Verification
REQ-040 Single fetch, ibus_adr=0x100, ack 2 cycles after grant -> o_wb_adr=0x100, o_wb_sel=4'hf, o_ibus_ack once, rdt forwarded.
REQ-041 Simultaneous ibus/dbus requests after reset -> dbus granted first; the next tie grants ibus.
REQ-042 dbus store, adr=0x2000, dat=0xdeadbeef, sel=4'b0011 -> identical values on o_wb_*, o_wb_we=1, o_dbus_ack only.
REQ-043 TIMEOUT=4, no ack -> ack with rdt=0 in grant cycle 4, o_timeout pulses once, FSM in IDLE.
REQ-044 TIMEOUT=4, ack in grant cycle 4 -> real data forwarded, o_timeout=0.
REQ-045 i_dbus_cyc dropped mid-grant, then reset mid-grant -> no acks generated, o_wb_cyc=0 next cycle, state IDLE.
